fetch_unit: RTL

- Instruction fetch stage directly upstream of decode and immediate generation.
- Owns the PC and issues word requests to instruction memory over a valid/ready channel.
- Buffers returned words, tagged with their PC, in a small in-order queue.
- Presents the full 32-bit instruction word to decode over a valid/ready handshake.
- Supports redirect (branch/jump target) with flush of queued and in-flight fetches.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches and queues returned words for decode.
// Optional build macro FETCH_MISALIGN_EN adds fetch_fault and a FAULT state for misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_fault
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and payload is held while valid=1 and ready=0.
  // The memory response channel has no ready: every response is taken on arrival.

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] QDEPTH_L = (CW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [31:0]   q_data  [QDEPTH];
  logic [31:0]   q_pc    [QDEPTH];
  logic [AW-1:0] q_wr;
  logic [AW-1:0] q_rd;

  logic [31:0]   tag_mem [QDEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;

  logic [CW:0]   inflight_sum;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          deq;
  logic [31:0]   redirect_tgt;
  logic          redirect_bad;

`ifdef FETCH_MISALIGN_EN
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault  = (state == ST_FAULT);
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  assign redirect_bad   = 1'b0;
`endif

  // Credits cover both queued words and requests still in flight, including ones
  // that will be dropped, so a returning word always has a free queue slot.
  assign inflight_sum   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = (state == ST_RUN) && !redirect_valid && (inflight_sum < QDEPTH_L);
  assign imem_req_addr  = fetch_pc;

  assign instr_valid = (count != '0) && (state != ST_FAULT);
  assign instr       = q_data[q_rd];
  assign instr_pc    = q_pc[q_rd];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop != '0);
  assign rsp_keep = imem_rsp_valid && (drop == '0) && (state != ST_FAULT);
  assign deq      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i]  <= '0;
        q_pc[i]    <= '0;
        tag_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything queued or in flight belongs to the old path; a response landing
      // this very cycle is discarded here and so leaves the drop count.
      state       <= redirect_bad ? ST_FAULT : ST_RUN;
      fetch_pc    <= redirect_tgt;
      count       <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop        <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (state == ST_BOOT) begin
        state <= ST_RUN;
      end
      if (req_fire) begin
        tag_mem[tag_wr] <= fetch_pc;
        tag_wr          <= tag_wr + AW'(1);
        fetch_pc        <= fetch_pc + 32'd4;
      end
      if (rsp_drop) begin
        drop <= drop - CW'(1);
      end
      if (rsp_keep) begin
        q_data[q_wr] <= imem_rsp_data;
        q_pc[q_wr]   <= tag_mem[tag_rd];
        q_wr         <= q_wr + AW'(1);
        tag_rd       <= tag_rd + AW'(1);
      end
      if (deq) begin
        q_rd <= q_rd + AW'(1);
      end
      count       <= count + CW'(rsp_keep) - CW'(deq);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

endmodule
